// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the commit-trace buffer.
package trace_pkg;

    // Default widths; the record struct below describes the default-width layout.
    localparam int DEF_XLEN = 32;
    localparam int DEF_TS_W = 32;

    // One trace record in the bit order it is packed into each channel FIFO.
    typedef struct packed {
        logic [DEF_TS_W-1:0] ts;
        logic [DEF_XLEN-1:0] pc;
        logic [31:0]         inst;
        logic                wren;
        logic [4:0]          wrdst;
        logic [DEF_XLEN-1:0] wrdata;
        logic                lost;
    } trace_rec_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Record payload width excluding the lost bit (ts, pc, inst, wren, wrdst, wrdata).
    function automatic int rec_w(input int xlen, input int ts_w);
        return ts_w + xlen + 32 + 1 + 5 + xlen;
    endfunction

endpackage

// File: rtl/trace_chan_fifo.sv
// Per-channel record FIFO with lost-record tracking and a saturating drop counter.
module trace_chan_fifo
    import trace_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W:0]       dout,
    output logic             empty,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE = 1;
    localparam logic [CW-1:0]    CNT_ONE = 1;
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [CNT_W-1:0] DROP_ONE = 1;

    logic [W:0]       mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             accept;

    // Accept when there is room, or when a concurrent pop frees the slot being written.
    always_comb begin
        accept     = push && ((cnt_q != CNT_FULL) || pop);
        drop       = push && !accept;
        wptr_d     = accept ? wptr_q + PTR_ONE : wptr_q;
        rptr_d     = pop ? rptr_q + PTR_ONE : rptr_q;
        cnt_d      = cnt_q;
        if (accept && !pop)
            cnt_d = cnt_q + CNT_ONE;
        else if (!accept && pop)
            cnt_d = cnt_q - CNT_ONE;
        lost_d     = lost_q;
        if (accept)
            lost_d = 1'b0;
        else if (drop)
            lost_d = 1'b1;
        drop_cnt_d = drop_cnt_q;
        if (clr)
            drop_cnt_d = '0;
        else if (drop && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + DROP_ONE;
    end

    // Pointer, occupancy and loss-state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            lost_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            lost_q     <= lost_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage; the record carries the lost flag as it stood before this push.
    always_ff @(posedge clock) begin
        if (accept)
            mem_q[wptr_q] <= {din, lost_q};
    end

    assign dout     = mem_q[rptr_q];
    assign empty    = (cnt_q == '0);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: rtl/trace_commit_buffer.sv
// Multi-channel commit-trace capture: timestamp, per-channel FIFOs, round-robin merge.
module trace_commit_buffer
    import trace_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [NUM_CH*XLEN-1:0]        ch_pc,
    input  logic [NUM_CH*32-1:0]          ch_inst,
    input  logic [NUM_CH-1:0]             ch_wren,
    input  logic [NUM_CH*5-1:0]           ch_wrdst,
    input  logic [NUM_CH*XLEN-1:0]        ch_wrdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ch_idx_w(NUM_CH)-1:0]   out_ch,
    output logic [TS_W-1:0]               out_ts,
    output logic [XLEN-1:0]               out_pc,
    output logic [31:0]                   out_inst,
    output logic                          out_wren,
    output logic [4:0]                    out_wrdst,
    output logic [XLEN-1:0]               out_wrdata,
    output logic                          out_lost,
    output logic [NUM_CH*CNT_W-1:0]       drop_cnt,
    output logic                          overflow
);

    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam int PW   = rec_w(XLEN, TS_W);
    localparam logic [TS_W-1:0] TS_ONE  = 1;
    localparam logic [CH_W-1:0] LAST_RST = CH_W'(NUM_CH - 1);

    logic [TS_W-1:0]              ts_q, ts_d;
    logic [NUM_CH-1:0]            empty, pop, drop;
    logic [NUM_CH-1:0][PW:0]      fdout;
    logic [PW:0]                  rec_q, rec_d;
    logic [CH_W-1:0]              ch_q, ch_d, last_q, last_d;
    logic                         out_valid_q, out_valid_d;
    logic                         overflow_q, overflow_d;
    logic                         load, found;
    int                           idx, win;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            trace_chan_fifo #(
                .W     (PW),
                .DEPTH (DEPTH),
                .CNT_W (CNT_W)
            ) u_fifo (
                .clock    (clock),
                .reset    (reset),
                .clr      (clr),
                .push     (en && ch_valid[gi]),
                .pop      (pop[gi]),
                .din      ({ts_q,
                            ch_pc[gi*XLEN +: XLEN],
                            ch_inst[gi*32 +: 32],
                            ch_wren[gi],
                            ch_wrdst[gi*5 +: 5],
                            ch_wrdata[gi*XLEN +: XLEN]}),
                .dout     (fdout[gi]),
                .empty    (empty[gi]),
                .drop_cnt (drop_cnt[gi*CNT_W +: CNT_W]),
                .drop     (drop[gi])
            );
        end
    endgenerate

    // Round-robin grant into the output register whenever it is empty or firing.
    always_comb begin
        ts_d        = ts_q + TS_ONE;
        load        = !out_valid_q || out_ready;
        found       = 1'b0;
        win         = 0;
        idx         = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_q) + k) % NUM_CH;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        pop         = '0;
        out_valid_d = out_valid_q;
        rec_d       = rec_q;
        ch_d        = ch_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                pop[win] = 1'b1;
                rec_d    = fdout[win];
                ch_d     = CH_W'(win);
                last_d   = CH_W'(win);
            end
        end
        // clr beats a same-cycle drop.
        overflow_d  = clr ? 1'b0 : (overflow_q | (|drop));
    end

    // Timestamp, output register, arbiter pointer and sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q        <= '0;
            rec_q       <= '0;
            ch_q        <= '0;
            last_q      <= LAST_RST;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            rec_q       <= rec_d;
            ch_q        <= ch_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign {out_ts, out_pc, out_inst, out_wren, out_wrdst, out_wrdata, out_lost} = rec_q;
    assign out_valid = out_valid_q;
    assign out_ch    = ch_q;
    assign overflow  = overflow_q;

endmodule
